// File: rtl/serial_add_seq.sv
// Bit-serial adder: one full-add slice plus a carry flop, LSB first, one bit per clock.
// Optional SERIAL_ADD_SUB_EN adds a 'sub' input so the block computes a-b instead of a+b.
module serial_add_seq #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
`ifdef SERIAL_ADD_SUB_EN
  input  logic             sub,
`endif
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic [1:0]       dbg_state
);

  // Handshake: start is sampled only while idle (busy=0). An accepted start
  // produces exactly one done pulse, and sum/cout are valid in that cycle.
  // Any start seen while busy is dropped, not queued.

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam int CW = $clog2(WIDTH + 1);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  state_t           state;
  logic [WIDTH-1:0] a_sh;
  logic [WIDTH-1:0] b_sh;
  logic [WIDTH-1:0] res_sh;
  logic [WIDTH-1:0] res_next;
  logic [WIDTH-1:0] s_msb;
  logic [CW-1:0]    cnt;
  logic             carry;
  logic             s;
  logic             carry_next;

  // The single shared full-add slice.
  always_comb begin
    s          = a_sh[0] ^ b_sh[0] ^ carry;
    carry_next = (a_sh[0] & b_sh[0]) | (a_sh[0] & carry) | (b_sh[0] & carry);
    s_msb             = '0;
    s_msb[WIDTH-1]    = s;
    res_next          = (res_sh >> 1) | s_msb;
  end

  assign dbg_state = state;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state  <= IDLE;
      busy   <= 1'b0;
      done   <= 1'b0;
      sum    <= '0;
      cout   <= 1'b0;
      carry  <= 1'b0;
      cnt    <= '0;
      a_sh   <= '0;
      b_sh   <= '0;
      res_sh <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            a_sh   <= a;
`ifdef SERIAL_ADD_SUB_EN
            // Two's-complement subtract: invert B and inject a carry-in of 1.
            b_sh   <= sub ? ~b : b;
            carry  <= sub;
`else
            b_sh   <= b;
            carry  <= 1'b0;
`endif
            res_sh <= '0;
            cnt    <= '0;
            busy   <= 1'b1;
            state  <= RUN;
          end
        end
        RUN: begin
          a_sh   <= a_sh >> 1;
          b_sh   <= b_sh >> 1;
          carry  <= carry_next;
          res_sh <= res_next;
          cnt    <= cnt + CW'(1);
          // Outputs move only here, so partial sums never leak out.
          if (cnt == LAST) begin
            sum   <= res_next;
            cout  <= carry_next;
            done  <= 1'b1;
            state <= DONE;
          end
        end
        DONE: begin
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: begin
          busy  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_serial_add_seq.sv
// Directed bench for serial_add_seq: a WIDTH=8 and a WIDTH=1 instance, each with
// an expected-result queue drained by a done-triggered monitor.
module tb_serial_add_seq;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;

  logic       start8 = 1'b0;
  logic [7:0] a8 = '0, b8 = '0;
  logic       busy8, done8, cout8;
  logic [7:0] sum8;
  logic [1:0] st8;

  logic       start1 = 1'b0;
  logic [0:0] a1 = '0, b1 = '0;
  logic       busy1, done1, cout1;
  logic [0:0] sum1;
  logic [1:0] st1;

`ifdef SERIAL_ADD_SUB_EN
  logic       sub8 = 1'b0;
  logic       sub1 = 1'b0;
`endif

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  logic [8:0] exp8_q[$];
  int         t8_q[$];
  logic [1:0] exp1_q[$];
  int         t1_q[$];

  serial_add_seq #(.WIDTH(8)) u8 (
    .clk(clk), .rst_n(rst_n), .start(start8), .a(a8), .b(b8),
`ifdef SERIAL_ADD_SUB_EN
    .sub(sub8),
`endif
    .busy(busy8), .done(done8), .sum(sum8), .cout(cout8), .dbg_state(st8)
  );

  serial_add_seq #(.WIDTH(1)) u1 (
    .clk(clk), .rst_n(rst_n), .start(start1), .a(a1), .b(b1),
`ifdef SERIAL_ADD_SUB_EN
    .sub(sub1),
`endif
    .busy(busy1), .done(done1), .sum(sum1), .cout(cout1), .dbg_state(st1)
  );

  // Clock / reset
  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  initial begin
    #200000;
    $display("FAIL watchdog: act=timeout req=finish");
    $fatal(1);
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("FAIL %s: act=0x%0h req=0x%0h (cyc %0d)", name, act, expv, cyc);
    end
  endtask

  // Scoreboard monitors
  always @(negedge clk) begin
    if (done8 === 1'b1) begin
      if (exp8_q.size() == 0) begin
        chk("u8_unexpected_done", 1, 0);
      end else begin
        chk("u8_result", {cout8, sum8}, exp8_q.pop_front());
        chk("u8_done_cycle", cyc, t8_q.pop_front());
      end
    end
    if (done1 === 1'b1) begin
      if (exp1_q.size() == 0) begin
        chk("u1_unexpected_done", 1, 0);
      end else begin
        chk("u1_result", {cout1, sum1}, exp1_q.pop_front());
        chk("u1_done_cycle", cyc, t1_q.pop_front());
      end
    end
  end

  // Drivers
  task automatic run8(input logic [7:0] av, input logic [7:0] bv, input logic [8:0] expv);
    int nb;
    bit partial;
    logic [7:0] s0;
    @(negedge clk);
    s0 = sum8;
    start8 = 1'b1; a8 = av; b8 = bv;
    exp8_q.push_back(expv);
    t8_q.push_back(cyc + 9);
    @(negedge clk);
    start8 = 1'b0;
    a8 = 8'($urandom); b8 = 8'($urandom);
    nb = 0; partial = 0;
    while (busy8 && nb < 40) begin
      if (!done8 && sum8 !== s0) partial = 1;
      nb++;
      @(negedge clk);
    end
    chk("u8_busy_len", nb, 9);
    chk("u8_no_partial_sum", partial, 0);
  endtask

  task automatic wait_idle8();
    int n = 0;
    while (busy8 !== 1'b0 && n < 40) begin
      n++;
      @(negedge clk);
    end
    if (n >= 40) chk("u8_idle_timeout", 1, 0);
  endtask

  task automatic run1(input logic av, input logic bv, input logic [1:0] expv);
    int nb;
    @(negedge clk);
    start1 = 1'b1; a1 = av; b1 = bv;
    exp1_q.push_back(expv);
    t1_q.push_back(cyc + 2);
    @(negedge clk);
    start1 = 1'b0;
    nb = 0;
    while (busy1 && nb < 20) begin
      nb++;
      @(negedge clk);
    end
    chk("u1_busy_len", nb, 2);
  endtask

  logic [7:0] va[3] = '{8'h0F, 8'hFF, 8'hA5};
  logic [7:0] vb[3] = '{8'h01, 8'h01, 8'h5A};
  logic [8:0] vr[3] = '{9'h010, 9'h100, 9'h0FF};
  logic [1:0] w1r[4] = '{2'b00, 2'b01, 2'b01, 2'b10};

  initial begin
    repeat (3) @(negedge clk);
    chk("rst_busy8", busy8, 0);
    chk("rst_done8", done8, 0);
    chk("rst_sum8", {cout8, sum8}, 0);
    chk("rst_state8", st8, 0);
    chk("rst_sum1", {busy1, done1, cout1, sum1}, 0);
    rst_n = 1'b1;

    for (int i = 0; i < 3; i++) run8(va[i], vb[i], vr[i]);

    // start held high through RUN/DONE: only the op accepted in IDLE counts
    @(negedge clk);
    start8 = 1'b1; a8 = 8'h12; b8 = 8'h34;
    exp8_q.push_back(9'h046);
    t8_q.push_back(cyc + 9);
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      a8 = 8'h33; b8 = 8'h33;
    end
    exp8_q.push_back(9'h066);
    t8_q.push_back(cyc + 9);
    @(negedge clk);
    start8 = 1'b0;
    wait_idle8();
    chk("u8_hold_sum", sum8, 8'h66);

    // reset while processing bit 4
    @(negedge clk);
    start8 = 1'b1; a8 = 8'h44; b8 = 8'h44;
    @(negedge clk);
    start8 = 1'b0;
    repeat (4) @(negedge clk);
    chk("u8_mid_busy", busy8, 1);
    rst_n = 1'b0; start8 = 1'b1;
    @(negedge clk);
    chk("u8_abort_busy", busy8, 0);
    chk("u8_abort_done", done8, 0);
    chk("u8_abort_sum", {cout8, sum8}, 0);
    rst_n = 1'b1; start8 = 1'b0;
    repeat (12) @(negedge clk);
    chk("u8_abort_idle", busy8, 0);
    run8(8'h10, 8'h20, 9'h030);

`ifdef SERIAL_ADD_SUB_EN
    sub8 = 1'b1;
    run8(8'h05, 8'h07, 9'h0FE);
    run8(8'h07, 8'h05, 9'h102);
    sub8 = 1'b0;
    run8(8'h07, 8'h05, 9'h00C);
`endif

    for (int i = 0; i < 4; i++) run1(i[1], i[0], w1r[i]);

    repeat (5) @(negedge clk);
    chk("u8_queue_drained", exp8_q.size(), 0);
    chk("u1_queue_drained", exp1_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
